// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin sharing of one pipelined AES-128 core with tagged, credit-protected responses
// Optional AES_ARB_PRIO0_EN: requester 0 takes strict priority over the round robin.
module aes_core_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = 1,
    parameter int CORE_LAT   = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_state,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   core_in_valid,
    output logic [127:0]           core_in_state,
    output logic [127:0]           core_key,
    input  logic                   core_out_valid,
    input  logic [127:0]           core_out_state,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [127:0]           rsp_state,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   tag_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]              credit;
    logic [ID_W-1:0]               rr_ptr;
    logic [ID_W-1:0]               gnt_idx;
    logic                          gnt_found;
    logic                          accept;
    logic                          ptr_upd;
    logic                          pop;
    logic [ID_W-1:0]               issue_id;
    logic [CORE_LAT-1:0]           tag_v;
    logic [CORE_LAT-1:0][ID_W-1:0] tag_id;
    logic [ID_W+127:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              fifo_cnt;
    logic                          fifo_full;
    logic                          fifo_wr;

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_found && req_valid[rr_next(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_next(rr_ptr, k);
            end
        end
`ifdef AES_ARB_PRIO0_EN
        if (req_valid[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = '0;
        end
`endif
    end

    // Credits count FIFO slots not yet claimed by an issued block, so the core can never overrun the FIFO.
    assign accept = gnt_found && (credit != '0);
    assign pop    = rsp_valid && rsp_ready;

`ifdef AES_ARB_PRIO0_EN
    assign ptr_upd = accept && (gnt_idx != '0);
`else
    assign ptr_upd = accept;
`endif

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            credit        <= FULL_CNT;
            core_in_valid <= 1'b0;
            core_in_state <= '0;
            core_key      <= '0;
            issue_id      <= '0;
        end else begin
            core_in_valid <= accept;
            if (accept) begin
                core_in_state <= req_state[128*gnt_idx +: 128];
                core_key      <= req_key[128*gnt_idx +: 128];
                issue_id      <= gnt_idx;
            end
            if (ptr_upd) begin
                rr_ptr <= gnt_idx;
            end
            if (accept && !pop) begin
                credit <= credit - CNT_W'(1);
            end else if (pop && !accept && credit != FULL_CNT) begin
                credit <= credit + CNT_W'(1);
            end
        end
    end

    // Stage CORE_LAT-1 lines up with core_out_valid for the block issued CORE_LAT cycles earlier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[CORE_LAT-2:0], core_in_valid};
            tag_id <= {tag_id[CORE_LAT-2:0], issue_id};
        end
    end

    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign fifo_wr   = core_out_valid && !fifo_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tag_err  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= {tag_id[CORE_LAT-1], core_out_state};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if ((core_out_valid != tag_v[CORE_LAT-1]) || (core_out_valid && fifo_full)) begin
                tag_err <= 1'b1;
            end
        end
    end

    assign rsp_valid           = (fifo_cnt != '0);
    assign {rsp_id, rsp_state} = fifo_mem[rd_ptr];

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Round-robin scheduler that shares one fully pipelined AES-128 core between NUM_REQ requesters. It accepts plaintext/key pairs over valid/ready handshakes and issues at most one block per cycle into the core. It tracks each block's requester ID through a tag pipeline matched to the core latency. The core has no backpressure, so results are buffered in a credit-protected output FIFO and returned on a single valid/ready stream tagged with the requester ID.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, 1, requester-ID width; 2**ID_W >= NUM_REQ
CORE_LAT, 11, cycles from core IN_valid to core OUT_valid
FIFO_DEPTH, 16, output FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid, one bit per requester
req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_state  in  NUM_REQ*128  plaintexts; requester i at [128*i +: 128]
req_key  in  NUM_REQ*128  keys; requester i at [128*i +: 128]
core_in_valid  out  1  to core IN_valid
core_in_state  out  128  to core IN_state
core_key  out  128  to core key
core_out_valid  in  1  from core OUT_valid
core_out_state  in  128  from core OUT_state
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_state  out  128  ciphertext
rsp_id  out  ID_W  originating requester
tag_err  out  1  sticky: core output with no matching tag, or tag with no core output

Behaviour:
- Reset values: req_ready=0, core_in_valid=0, core_in_state=0, core_key=0, rsp_valid=0, rsp_state=0, rsp_id=0, tag_err=0. Credit=FIFO_DEPTH. RR pointer=NUM_REQ-1, so requester 0 wins first. Tag pipeline is cleared and FIFO is empty.
- Credit counter (width clog2(FIFO_DEPTH)+1): decrements on an accepted request and increments on a response pop (rsp_valid & rsp_ready). When both occur in the same cycle, it is unchanged. Credit never exceeds FIFO_DEPTH and never goes below 0.
- Arbitration (combinational): when credit>0, grant the first i with req_valid[i]=1, scanning from ptr+1 modulo NUM_REQ. Set req_ready[i]=1 only for the granted i. When credit==0, req_ready is all zeros.
- req_ready does not depend on rsp_ready in the same cycle. A pop in cycle T frees a credit from T+1.
- On acceptance: ptr<=granted index. core_in_valid<=1, and core_in_state/core_key register the granted requester's data on the same edge. With no acceptance, core_in_valid<=0 and the data registers hold their values.
- Tag pipeline: CORE_LAT-stage shift of {valid, id}, loaded from {core_in_valid, granted id registered with the issue}. Stage CORE_LAT-1 is aligned with core_out_valid.
- FIFO write: on core_out_valid, store {tag id, core_out_state}.
- Tag mismatch: if core_out_valid != tag valid at the aligned stage, set tag_err=1. It holds until reset.
- FIFO output: registered. rsp_valid=!empty, and rsp_state/rsp_id present the head entry. Pop on rsp_valid & rsp_ready.
- A simultaneous write and pop when full cannot occur, because credits guarantee the write fits. A write while full sets tag_err and drops the data.
- Latency with an empty FIFO: request accepted at edge T, core_in_valid high from T+1, core_out_valid at T+1+CORE_LAT, rsp_valid high from T+2+CORE_LAT.
- Throughput: 1 block/cycle sustained while rsp_ready=1 and FIFO_DEPTH >= CORE_LAT+2.
- Per-requester ordering: responses preserve acceptance order, both globally and per requester.
- Reset mid-operation: all in-flight blocks and FIFO contents are discarded, and credits are restored. The core is reset by the same reset_n, so no stale output is attributed.

Optional Feature:
AES_ARB_PRIO0_EN — when defined, requester 0 has strict priority: if req_valid[0] and credit>0, it is granted regardless of ptr. Round robin among the others continues from ptr, and ptr updates only on grants to requesters 1..NUM_REQ-1. When undefined, plain round robin applies to all requesters.

Test Plan:
- Single request, requester 0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, rsp_ready=1 -> rsp_state=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_valid exactly CORE_LAT+2 cycles after acceptance.
- Requesters 0 and 1 both hold valid for 8 cycles -> grants alternate 0,1,0,1…; 8 responses in the same order with ids 0,1,0,1…; tag_err=0.
- rsp_ready=0 with continuous requests -> exactly FIFO_DEPTH (16) accepts, then req_ready=0. Raise rsp_ready -> one new accept per pop, with no loss or duplication.
- Pop and accept in the same cycle at credit=1 -> credit stays 1 and the next cycle still accepts.
- reset_n low for 1 cycle with 5 blocks in flight -> all outputs at reset values, no rsp_valid afterwards, credit=16, next request completes correctly.
- With AES_ARB_PRIO0_EN, requesters 0,1,2 continuously valid -> only 0 granted. Drop req_valid[0] -> 1 and 2 alternate.
